// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared types and widths for the game pipeline (frame scheduler, ball,
// platform, collision, renderer).
//   PX_W / PY_W    pixel X / Y coordinate widths
//   BSZ_W          ball size width
//   PSZ_W          platform half-width width
//   frame_state_e  frame scheduler states
//   geometry_t     one frame's worth of ball + platform geometry
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int PX_W  = 10;
    localparam int PY_W  = 9;
    localparam int BSZ_W = 3;
    localparam int PSZ_W = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        BUSY   = 2'd2,
        COMMIT = 2'd3
    } frame_state_e;

    typedef struct packed {
        logic [PX_W-1:0]  x;
        logic [PY_W-1:0]  y;
        logic [BSZ_W-1:0] ball_size;
        logic [PX_W-1:0]  platx;
        logic [PY_W-1:0]  platy;
        logic [PSZ_W-1:0] plat_size;
    } geometry_t;

    // Saturating increment used by event counters that must not wrap.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/frame_scheduler_if.sv
// ---------------------------------------------------------------------------
// frame_scheduler_if
// Link between the frame scheduler and the game engine (ball, platform,
// collision).
//   cal_frame   scheduler -> engine : 1-cycle start-of-frame pulse
//   frame_done  engine -> scheduler : 1-cycle frame-complete pulse
//   ballX/ballY/ball_size/platX/platY/plat_size
//               engine -> scheduler : live geometry
// Modports: master = scheduler side, slave = engine side.
// ---------------------------------------------------------------------------
interface frame_scheduler_if;
    import game_pkg::*;

    logic             cal_frame;
    logic             frame_done;
    logic [PX_W-1:0]  ballX;
    logic [PY_W-1:0]  ballY;
    logic [BSZ_W-1:0] ball_size;
    logic [PX_W-1:0]  platX;
    logic [PY_W-1:0]  platY;
    logic [PSZ_W-1:0] plat_size;

    modport master (
        output cal_frame,
        input  frame_done, ballX, ballY, ball_size, platX, platY, plat_size
    );

    modport slave (
        input  cal_frame,
        output frame_done, ballX, ballY, ball_size, platX, platY, plat_size
    );

endinterface

// File: rtl/frame_divider.sv
// ---------------------------------------------------------------------------
// frame_divider
// Counts vsync ticks 0..FRAME_DIV-1 and flags the tick that closes a game
// frame. The count is held at zero while the game is paused so that a resume
// always waits a full FRAME_DIV ticks.
//   clk, rst     clock, synchronous active-high reset
//   i_vsync      1-cycle vertical-blank tick
//   i_run        1 = game running; 0 = clear the count
//   o_boundary   combinational: this vsync is a frame boundary
// ---------------------------------------------------------------------------
module frame_divider #(
    parameter int FRAME_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_vsync,
    input  logic i_run,
    output logic o_boundary
);
    localparam int               DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] LAST  = DIV_W'(FRAME_DIV - 1);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || !i_run) begin
            r_cnt <= '0;
        end else if (i_vsync) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + DIV_W'(1);
        end
    end

    assign o_boundary = i_run & i_vsync & (r_cnt == LAST);

endmodule

// File: rtl/frame_scheduler.sv
// ---------------------------------------------------------------------------
// frame_scheduler
// Starts one game frame per FRAME_DIV vsync ticks (or per i_step while
// paused), waits for the collision engine, then snapshots the geometry into
// the display registers in one clock so the renderer never sees a torn frame.
// Dropped frame starts and hung frames are reported.
//   clk, rst        clock, synchronous active-high reset
//   i_vsync         1-cycle vertical-blank tick
//   i_game_run      1 = free-running frames, 0 = paused
//   i_step          1-cycle single-step request (honoured only while paused)
//   eng             engine link: cal_frame out, frame_done + geometry in
//   o_busy          frame in flight (ISSUE or BUSY)
//   o_disp_*        committed geometry snapshot
//   o_disp_update   1-cycle pulse when o_disp_* change
//   o_frame_cnt     committed frames (wraps)
//   o_overrun_cnt   dropped frame starts (saturates)
//   o_timeout_err   sticky watchdog flag
// ---------------------------------------------------------------------------
module frame_scheduler import game_pkg::*; #(
    parameter int FRAME_DIV = 1,
    parameter int TIMEOUT   = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_vsync,
    input  logic                 i_game_run,
    input  logic                 i_step,
    frame_scheduler_if.master    eng,
    output logic                 o_busy,
    output logic [PX_W-1:0]      o_disp_ballX,
    output logic [PY_W-1:0]      o_disp_ballY,
    output logic [BSZ_W-1:0]     o_disp_ball_size,
    output logic [PX_W-1:0]      o_disp_platX,
    output logic [PY_W-1:0]      o_disp_platY,
    output logic [PSZ_W-1:0]     o_disp_plat_size,
    output logic                 o_disp_update,
    output logic [15:0]          o_frame_cnt,
    output logic [7:0]           o_overrun_cnt,
    output logic                 o_timeout_err
);
    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    frame_state_e    r_state;
    logic            r_cal_frame;
    logic            r_busy;
    geometry_t       r_disp;
    logic            r_disp_update;
    logic [15:0]     r_frame_cnt;
    logic [7:0]      r_overrun_cnt;
    logic            r_timeout_err;
    logic [WD_W-1:0] r_wdog;

    logic            w_boundary;
    logic            w_trigger;
    geometry_t       w_live;

    frame_divider #(.FRAME_DIV(FRAME_DIV)) u_divider (
        .clk        (clk),
        .rst        (rst),
        .i_vsync    (i_vsync),
        .i_run      (i_game_run),
        .o_boundary (w_boundary)
    );

    // i_step is meaningless while running; only the divider starts frames then.
    assign w_trigger = w_boundary | (~i_game_run & i_step);

    assign w_live = '{x:         eng.ballX,
                      y:         eng.ballY,
                      ball_size: eng.ball_size,
                      platx:     eng.platX,
                      platy:     eng.platY,
                      plat_size: eng.plat_size};

    // NOTE: every register here is state, so it is written with <= only;
    // the pulse outputs get a default of 0 at the top of the clocked branch
    // and are raised on the one transition that owns them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cal_frame   <= 1'b0;
            r_busy        <= 1'b0;
            r_disp        <= '0;
            r_disp_update <= 1'b0;
            r_frame_cnt   <= '0;
            r_overrun_cnt <= '0;
            r_timeout_err <= 1'b0;
            r_wdog        <= '0;
        end else begin
            r_cal_frame   <= 1'b0;
            r_disp_update <= 1'b0;

            // A frame boundary that arrives while a frame is still in flight
            // (including the commit cycle) is dropped, never queued.
            if (w_boundary && r_state != IDLE) begin
                r_overrun_cnt <= sat_inc8(r_overrun_cnt);
            end

            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_state     <= ISSUE;
                        r_cal_frame <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                ISSUE: begin
                    r_state <= BUSY;
                    r_wdog  <= '0;
                end
                BUSY: begin
                    // The snapshot is taken on the done cycle itself, so the
                    // engine may move on to the next frame's geometry at once.
                    if (eng.frame_done) begin
                        r_state       <= COMMIT;
                        r_busy        <= 1'b0;
                        r_disp        <= w_live;
                        r_disp_update <= 1'b1;
                        r_frame_cnt   <= r_frame_cnt + 16'd1;
                    end else if (r_wdog == WD_LAST) begin
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + WD_W'(1);
                    end
                end
                COMMIT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign eng.cal_frame     = r_cal_frame;
    assign o_busy            = r_busy;
    assign o_disp_ballX      = r_disp.x;
    assign o_disp_ballY      = r_disp.y;
    assign o_disp_ball_size  = r_disp.ball_size;
    assign o_disp_platX      = r_disp.platx;
    assign o_disp_platY      = r_disp.platy;
    assign o_disp_plat_size  = r_disp.plat_size;
    assign o_disp_update     = r_disp_update;
    assign o_frame_cnt       = r_frame_cnt;
    assign o_overrun_cnt     = r_overrun_cnt;
    assign o_timeout_err     = r_timeout_err;

endmodule

// File: tb/tb_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_frame_scheduler
// Two schedulers share vsync/run/step/rst: instance A (FRAME_DIV=1,
// TIMEOUT=1000) and instance B (FRAME_DIV=3, TIMEOUT=16). Each has its own
// engine link. A frame-level reference model predicts every output of both
// instances each cycle; directed scenarios are followed by random traffic.
// ---------------------------------------------------------------------------
module tb_frame_scheduler;
    import game_pkg::*;

    localparam int P_IDLE = 0, P_ISSUE = 1, P_BUSY = 2, P_COMMIT = 3;

    typedef struct {
        int        phase;
        int        div;
        int        age;
        bit        cal;
        bit        busy;
        bit        upd;
        bit        err;
        geometry_t disp;
        int        fcnt;
        int        ovr;
    } mdl_t;

    logic clk = 1'b0;
    logic rst, vsync, run, step;
    always #5 clk = ~clk;

    frame_scheduler_if if_a ();
    frame_scheduler_if if_b ();

    logic             a_busy, a_upd, a_err, b_busy, b_upd, b_err;
    logic [15:0]      a_fcnt, b_fcnt;
    logic [7:0]       a_ovr, b_ovr;
    logic [PX_W-1:0]  a_bx, a_px, b_bx, b_px;
    logic [PY_W-1:0]  a_by, a_py, b_by, b_py;
    logic [BSZ_W-1:0] a_bs, b_bs;
    logic [PSZ_W-1:0] a_ps, b_ps;
    geometry_t        a_disp, b_disp;
    assign a_disp = {a_bx, a_by, a_bs, a_px, a_py, a_ps};
    assign b_disp = {b_bx, b_by, b_bs, b_px, b_py, b_ps};

    frame_scheduler #(.FRAME_DIV(1), .TIMEOUT(1000)) dut_a (
        .clk(clk), .rst(rst), .i_vsync(vsync), .i_game_run(run), .i_step(step),
        .eng(if_a.master), .o_busy(a_busy),
        .o_disp_ballX(a_bx), .o_disp_ballY(a_by), .o_disp_ball_size(a_bs),
        .o_disp_platX(a_px), .o_disp_platY(a_py), .o_disp_plat_size(a_ps),
        .o_disp_update(a_upd), .o_frame_cnt(a_fcnt), .o_overrun_cnt(a_ovr),
        .o_timeout_err(a_err)
    );

    frame_scheduler #(.FRAME_DIV(3), .TIMEOUT(16)) dut_b (
        .clk(clk), .rst(rst), .i_vsync(vsync), .i_game_run(run), .i_step(step),
        .eng(if_b.master), .o_busy(b_busy),
        .o_disp_ballX(b_bx), .o_disp_ballY(b_by), .o_disp_ball_size(b_bs),
        .o_disp_platX(b_px), .o_disp_platY(b_py), .o_disp_plat_size(b_ps),
        .o_disp_update(b_upd), .o_frame_cnt(b_fcnt), .o_overrun_cnt(b_ovr),
        .o_timeout_err(b_err)
    );

    int        n_checks = 0;
    int        n_errors = 0;
    int        cyc = 0;
    mdl_t      m [2];
    int        fdiv [2] = '{1, 3};
    int        tout [2] = '{1000, 16};
    string     nm [2] = '{"A", "B"};
    int        dly [2];
    int        since [2];
    int        cal_cnt [2], upd_cnt [2], first_cal [2], last_cal [2], last_upd [2];
    bit        force_done, rnd_done;
    geometry_t g;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Frame-level behaviour of one scheduler for one clock.
    function automatic mdl_t model_next(input mdl_t s, input int fd, input int to,
                                        input bit r, input bit vs, input bit rn,
                                        input bit st, input bit dn, input geometry_t gi);
        mdl_t n;
        bit   boundary;
        n     = s;
        n.cal = 0;
        n.upd = 0;
        if (r) begin
            n.phase = P_IDLE; n.div = 0; n.age = 0; n.busy = 0; n.err = 0;
            n.disp  = '0;     n.fcnt = 0; n.ovr = 0;
            return n;
        end
        boundary = rn && vs && (s.div == fd - 1);
        n.div    = !rn ? 0 : (vs ? (s.div + 1) % fd : s.div);
        if (boundary && s.phase != P_IDLE)
            n.ovr = (s.ovr < 255) ? s.ovr + 1 : 255;
        case (s.phase)
            P_IDLE: if (boundary || (!rn && st)) begin
                n.phase = P_ISSUE; n.cal = 1; n.busy = 1;
            end
            P_ISSUE: begin
                n.phase = P_BUSY; n.age = 0;
            end
            P_BUSY: begin
                n.age = s.age + 1;
                if (dn) begin
                    n.phase = P_COMMIT; n.busy = 0; n.upd = 1; n.disp = gi;
                    n.fcnt  = (s.fcnt + 1) % 65536;
                end else if (n.age == to) begin
                    n.phase = P_IDLE; n.busy = 0; n.err = 1;
                end
            end
            default: n.phase = P_IDLE;
        endcase
        return n;
    endfunction

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            cal_cnt[i] = 0; upd_cnt[i] = 0; first_cal[i] = -1; last_cal[i] = -1; last_upd[i] = -1;
        end
    endtask

    task automatic rand_geom();
        g.x         = PX_W'($urandom);
        g.y         = PY_W'($urandom);
        g.ball_size = BSZ_W'($urandom);
        g.platx     = PX_W'($urandom);
        g.platy     = PY_W'($urandom);
        g.plat_size = PSZ_W'($urandom);
    endtask

    // One clock: drive engine responses, advance the model, then compare
    // every output on the falling edge.
    task automatic cycle();
        bit        dn [2];
        bit        ocal [2], obusy [2], oupd [2], oerr [2];
        int        ofcnt [2], oovr [2];
        geometry_t odisp [2];
        for (int i = 0; i < 2; i++)
            dn[i] = force_done | (rnd_done && ($urandom_range(0, 7) == 0)) |
                    (dly[i] >= 0 && since[i] == dly[i]);
        if_a.frame_done = dn[0];
        if_b.frame_done = dn[1];
        {if_a.ballX, if_a.ballY, if_a.ball_size, if_a.platX, if_a.platY, if_a.plat_size} = g;
        {if_b.ballX, if_b.ballY, if_b.ball_size, if_b.platX, if_b.platY, if_b.plat_size} = g;
        for (int i = 0; i < 2; i++)
            m[i] = model_next(m[i], fdiv[i], tout[i], rst, vsync, run, step, dn[i], g);
        @(negedge clk);
        cyc++;
        ocal[0] = if_a.cal_frame; obusy[0] = a_busy; oupd[0] = a_upd; oerr[0] = a_err;
        ofcnt[0] = int'(a_fcnt);  oovr[0] = int'(a_ovr); odisp[0] = a_disp;
        ocal[1] = if_b.cal_frame; obusy[1] = b_busy; oupd[1] = b_upd; oerr[1] = b_err;
        ofcnt[1] = int'(b_fcnt);  oovr[1] = int'(b_ovr); odisp[1] = b_disp;
        for (int i = 0; i < 2; i++) begin
            check({nm[i], " cal_frame"},   64'(ocal[i]),  64'(m[i].cal));
            check({nm[i], " busy"},        64'(obusy[i]), 64'(m[i].busy));
            check({nm[i], " disp_update"}, 64'(oupd[i]),  64'(m[i].upd));
            check({nm[i], " timeout_err"}, 64'(oerr[i]),  64'(m[i].err));
            check({nm[i], " frame_cnt"},   64'(ofcnt[i]), 64'(m[i].fcnt));
            check({nm[i], " overrun_cnt"}, 64'(oovr[i]),  64'(m[i].ovr));
            check({nm[i], " disp"},        64'(odisp[i]), 64'(m[i].disp));
            if (ocal[i]) begin
                if (cal_cnt[i] == 0) first_cal[i] = cyc;
                cal_cnt[i]++;
                last_cal[i] = cyc;
            end
            if (oupd[i]) begin
                upd_cnt[i]++;
                last_upd[i] = cyc;
            end
            if (m[i].cal) since[i] = 0;
            else if (since[i] >= 0 && since[i] < 1000000) since[i]++;
        end
    endtask

    initial begin
        int        vs_c;
        int        vs_at [6];
        int        saved_fcnt;
        geometry_t saved_disp;

        // NOTE: stimulus is driven with blocking assignments right after the
        // falling edge, so the rising edge always samples settled inputs.
        rst = 1'b1; vsync = 1'b0; run = 1'b0; step = 1'b0;
        force_done = 1'b0; rnd_done = 1'b0;
        dly = '{-1, -1}; since = '{-1, -1};
        rand_geom();
        clear_counts();
        repeat (3) cycle();
        check("reset A frame_cnt", 64'(a_fcnt), 64'd0);
        check("reset B busy", 64'(b_busy), 64'd0);
        rst = 1'b0; run = 1'b1;
        repeat (3) cycle();

        // 1: single frame on A, done 9 cycles after cal_frame.
        clear_counts();
        dly = '{9, -1};
        vsync = 1'b1; vs_c = cyc; cycle(); vsync = 1'b0;
        repeat (15) cycle();
        check("t1 A cal count", 64'(cal_cnt[0]), 64'd1);
        check("t1 A cal latency", 64'(last_cal[0] - vs_c), 64'd1);
        check("t1 A upd latency", 64'(last_upd[0] - last_cal[0]), 64'd10);
        check("t1 A frame_cnt", 64'(a_fcnt), 64'd1);

        // 2: six vsyncs, B divides by 3.
        run = 1'b0; cycle(); run = 1'b1; cycle();
        clear_counts();
        dly = '{9, 5};
        for (int k = 0; k < 6; k++) begin
            vsync = 1'b1; vs_at[k] = cyc; cycle(); vsync = 1'b0;
            repeat (11) cycle();
        end
        repeat (10) cycle();
        check("t2 B cal count", 64'(cal_cnt[1]), 64'd2);
        check("t2 B first cal", 64'(first_cal[1]), 64'(vs_at[2] + 1));
        check("t2 B last cal", 64'(last_cal[1]), 64'(vs_at[5] + 1));
        check("t2 B overrun", 64'(b_ovr), 64'd0);
        check("t2 A cal count", 64'(cal_cnt[0]), 64'd6);

        // 3: A never finishes; 299 further boundaries saturate the counter.
        dly = '{-1, 5};
        repeat (5) cycle();
        clear_counts();
        for (int k = 0; k < 300; k++) begin
            vsync = 1'b1; cycle(); vsync = 1'b0; cycle();
        end
        check("t3 A overrun sat", 64'(a_ovr), 64'hFF);
        check("t3 A cal count", 64'(cal_cnt[0]), 64'd1);
        check("t3 A still busy", 64'(a_busy), 64'd1);

        // 6b: reset while A is busy, then a late done must be ignored.
        clear_counts();
        rst = 1'b1; cycle(); rst = 1'b0;
        check("rst A busy", 64'(a_busy), 64'd0);
        check("rst A overrun", 64'(a_ovr), 64'd0);
        force_done = 1'b1; cycle(); force_done = 1'b0;
        repeat (3) cycle();
        check("rst late done A upd", 64'(upd_cnt[0]), 64'd0);
        check("rst late done A fcnt", 64'(a_fcnt), 64'd0);

        // 4: paused single-step; vsyncs and run-mode steps do nothing.
        run = 1'b0; dly = '{3, 3};
        repeat (2) cycle();
        clear_counts();
        step = 1'b1; vs_c = cyc; cycle(); step = 1'b0;
        repeat (8) cycle();
        check("t4 A step cal", 64'(cal_cnt[0]), 64'd1);
        check("t4 A step latency", 64'(last_cal[0] - vs_c), 64'd1);
        check("t4 B step cal", 64'(cal_cnt[1]), 64'd1);
        clear_counts();
        for (int k = 0; k < 6; k++) begin
            vsync = 1'b1; cycle(); vsync = 1'b0; repeat (3) cycle();
        end
        check("t4 paused vsync A", 64'(cal_cnt[0]), 64'd0);
        check("t4 paused vsync B", 64'(cal_cnt[1]), 64'd0);
        run = 1'b1; cycle();
        clear_counts();
        step = 1'b1; cycle(); step = 1'b0;
        repeat (5) cycle();
        check("t4 run step A", 64'(cal_cnt[0]), 64'd0);
        check("t4 run step B", 64'(cal_cnt[1]), 64'd0);

        // 5: B watchdog (TIMEOUT=16), then a fresh frame still starts.
        dly = '{3, -1};
        clear_counts();
        check("t5 B err before", 64'(b_err), 64'd0);
        saved_fcnt = m[1].fcnt;
        saved_disp = m[1].disp;
        for (int k = 0; k < 3; k++) begin
            vsync = 1'b1; cycle(); vsync = 1'b0; repeat (7) cycle();
        end
        repeat (12) cycle();
        check("t5 B timeout_err", 64'(b_err), 64'd1);
        check("t5 B idle", 64'(b_busy), 64'd0);
        check("t5 B fcnt kept", 64'(b_fcnt), 64'(saved_fcnt));
        check("t5 B disp kept", 64'(b_disp), 64'(saved_disp));
        for (int k = 0; k < 3; k++) begin
            vsync = 1'b1; cycle(); vsync = 1'b0; repeat (7) cycle();
        end
        check("t5 B cal count", 64'(cal_cnt[1]), 64'd2);

        // 6: snapshot uses the geometry present on the done cycle.
        run = 1'b0; dly = '{-1, -1};
        repeat (25) cycle();
        step = 1'b1; cycle(); step = 1'b0;
        repeat (3) cycle();
        g.x = 10'h155; force_done = 1'b1; cycle();
        g.x = 10'h0AA; force_done = 1'b0; cycle();
        cycle();
        check("t6 A disp ballX", 64'(a_bx), 64'h155);
        check("t6 B disp ballX", 64'(b_bx), 64'h155);

        // Random traffic.
        rnd_done = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            rst   = ($urandom_range(0, 299) == 0);
            vsync = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 39) == 0) run = ~run;
            step  = ($urandom_range(0, 14) == 0);
            rand_geom();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
